uart_tx_drain: RTL and testbench

- UART transmit serializer that sits directly downstream of the transmit FIFO.
- Pops one word at a time from the FIFO's read side and shifts it out on a single TX line.
- Frame format is 8N1 by default: start bit, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits, with programmable bit period.
- Runs on the same clock as the FIFO. The FIFO updates on the falling edge; this block updates on the rising edge.

---
 rtl/uart_tx_drain.sv | 144 ++++++++++++++
 tb/tb_uart_tx_drain.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_drain.sv
// UART transmit serializer draining a FIFO read port, one frame per word.
// Ports: clk, rst_n, fifo_empty, fifo_data in; fifo_read, tx, busy out.
module uart_tx_drain #(
    parameter int DATA_BITS = 8,
    parameter int CLK_DIV   = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 fifo_read,
    output logic                 tx,
    output logic                 busy
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(DATA_BITS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t               state, state_n;
    logic [DIV_W-1:0]     div, div_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_bit, par_n;
    logic                 tx_n;
    logic                 read_n;
    logic                 busy_n;
    logic                 bit_end;

    assign bit_end = (div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            div       <= '0;
            cnt       <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            tx        <= 1'b1;
            fifo_read <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            div       <= div_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            par_bit   <= par_n;
            tx        <= tx_n;
            fifo_read <= read_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        div_n   = div;
        cnt_n   = cnt;
        shreg_n = shreg;
        par_n   = par_bit;
        tx_n    = tx;
        read_n  = 1'b0;

        // Divider free-runs in every non-idle state and wraps on bit end.
        if (state != S_IDLE) begin
            div_n = bit_end ? '0 : div + DIV_W'(1);
        end

        unique case (state)
            S_IDLE: begin
                tx_n = 1'b1;
                if (!fifo_empty) begin
                    shreg_n = fifo_data;
                    par_n   = (PARITY == 2) ? ~^fifo_data : ^fifo_data;
                    read_n  = 1'b1;
                    tx_n    = 1'b0;
                    div_n   = '0;
                    cnt_n   = '0;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    tx_n    = shreg[0];
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (cnt == DATA_LAST) begin
                        cnt_n = '0;
                        if (PARITY != 0) begin
                            tx_n    = par_bit;
                            state_n = S_PAR;
                        end else begin
                            tx_n    = 1'b1;
                            state_n = S_STOP;
                        end
                    end else begin
                        cnt_n   = cnt + CNT_W'(1);
                        shreg_n = shreg >> 1;
                        tx_n    = shreg_n[0];
                    end
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    tx_n    = 1'b1;
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                tx_n = 1'b1;
                if (bit_end) begin
                    if (cnt == STOP_LAST) begin
                        cnt_n   = '0;
                        state_n = S_IDLE;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: three parameter sets, FIFO models, frame model.
// Ports: none.
module tb_uart_tx_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    int checks = 0;
    int failures = 0;

    int cdiv[3]  = '{4, 2, 2};
    int cpar[3]  = '{0, 1, 2};
    int cstop[3] = '{1, 2, 2};

    logic [7:0] mem [3][16];
    int wp[3] = '{0, 0, 0};
    int rp[3] = '{0, 0, 0};

    logic       fe[3];
    logic [7:0] fd[3];
    logic       rd[3];
    logic       txs[3];
    logic       bs[3];

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_fifo
            assign fe[g] = (wp[g] == rp[g]);
            assign fd[g] = mem[g][4'(rp[g])];
        end
    endgenerate

    // FIFO pops on the falling edge after a read pulse.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rd[d] && wp[d] != rp[d]) rp[d] <= rp[d] + 1;
        end
    end

    uart_tx_drain #(
        .DATA_BITS(8), .CLK_DIV(4), .PARITY(0), .STOP_BITS(1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fe[0]), .fifo_data(fd[0]),
        .fifo_read(rd[0]), .tx(txs[0]), .busy(bs[0])
    );

    uart_tx_drain #(
        .DATA_BITS(8), .CLK_DIV(2), .PARITY(1), .STOP_BITS(2)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fe[1]), .fifo_data(fd[1]),
        .fifo_read(rd[1]), .tx(txs[1]), .busy(bs[1])
    );

    uart_tx_drain #(
        .DATA_BITS(8), .CLK_DIV(2), .PARITY(2), .STOP_BITS(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fe[2]), .fifo_data(fd[2]),
        .fifo_read(rd[2]), .tx(txs[2]), .busy(bs[2])
    );

    task automatic push(input int d, input logic [7:0] w);
        mem[d][4'(wp[d])] = w;
        wp[d] = wp[d] + 1;
    endtask

    // Expected line activity from the capture edge of the first word:
    // each frame is a list of bits held div cycles, then one idle cycle.
    function automatic void model(
        input int div, input int par, input int stops,
        input logic [31:0] words, input int nw,
        output logic [127:0] etx, output logic [127:0] ebs,
        output logic [127:0] erd
    );
        int t;
        logic bits[$];
        logic [7:0] w;
        etx = '1;
        ebs = '0;
        erd = '0;
        t = 0;
        for (int i = 0; i < nw; i++) begin
            w = words[i*8 +: 8];
            bits = {};
            bits.push_back(1'b0);
            for (int b = 0; b < 8; b++) bits.push_back(w[b]);
            if (par == 1) bits.push_back(^w);
            if (par == 2) bits.push_back(~^w);
            for (int s = 0; s < stops; s++) bits.push_back(1'b1);
            if (t < 128) erd[t] = 1'b1;
            foreach (bits[b]) begin
                for (int j = 0; j < div; j++) begin
                    if (t < 128) begin
                        etx[t] = bits[b];
                        ebs[t] = 1'b1;
                    end
                    t++;
                end
            end
            t++;
        end
    endfunction

    // Waits for a read pulse, then records 128 cycles starting there.
    task automatic capture(
        input int d, input int bound, output int waited,
        output logic [127:0] otx, output logic [127:0] obs,
        output logic [127:0] ord
    );
        otx = '0;
        obs = '0;
        ord = '0;
        waited = 0;
        while (waited < bound) begin
            @(negedge clk);
            waited++;
            if (rd[d] === 1'b1) break;
        end
        if (rd[d] !== 1'b1) begin
            waited = -1;
            return;
        end
        for (int k = 0; k < 128; k++) begin
            if (k > 0) @(negedge clk);
            otx[k] = txs[d];
            obs[k] = bs[d];
            ord[k] = rd[d];
        end
    endtask

    task automatic test_reset();
        int wt;
        logic [7:0] w;
        logic [127:0] otx, obs, ord, etx, ebs, erd;
        w = 8'($urandom);
        push(0, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (txs[0] !== 1'b1 || rd[0] !== 1'b0 || bs[0] !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold: tx=%b read=%b busy=%b expected 1 0 0",
                         txs[0], rd[0], bs[0]);
            end
        end
        rst_n = 1'b1;
        model(cdiv[0], cpar[0], cstop[0], {24'h0, w}, 1, etx, ebs, erd);
        capture(0, 4, wt, otx, obs, ord);
        checks++;
        if (wt !== 1) begin
            failures++;
            $display("FAIL reset_first_capture: waited %0d expected 1", wt);
        end
        checks++;
        if (otx !== etx) begin
            failures++;
            $display("FAIL reset_frame_tx: got %h expected %h", otx, etx);
        end
    endtask

    task automatic test_single();
        int wt;
        logic [9:0] lb;
        logic [127:0] otx, obs, ord, etx, ebs, erd;
        push(0, 8'h55);
        model(cdiv[0], cpar[0], cstop[0], 32'h55, 1, etx, ebs, erd);
        capture(0, 4, wt, otx, obs, ord);
        checks++;
        if (wt !== 1) begin
            failures++;
            $display("FAIL single_start: waited %0d expected 1", wt);
        end
        checks++;
        if (otx !== etx) begin
            failures++;
            $display("FAIL single_tx: got %h expected %h", otx, etx);
        end
        checks++;
        if (obs !== ebs) begin
            failures++;
            $display("FAIL single_busy: got %h expected %h", obs, ebs);
        end
        checks++;
        if (ord !== erd) begin
            failures++;
            $display("FAIL single_read: got %h expected %h", ord, erd);
        end
        for (int i = 0; i < 10; i++) lb[i] = otx[i*4];
        checks++;
        if (lb !== 10'b1010101010) begin
            failures++;
            $display("FAIL single_bits: got %b expected 1010101010", lb);
        end
        checks++;
        if ($countones(obs) !== 40) begin
            failures++;
            $display("FAIL single_busy_len: got %0d expected 40",
                     $countones(obs));
        end
    endtask

    task automatic test_back_to_back();
        int wt;
        logic [127:0] otx, obs, ord, etx, ebs, erd, er2;
        push(0, 8'hA3);
        push(0, 8'h0F);
        model(cdiv[0], cpar[0], cstop[0], 32'h0FA3, 2, etx, ebs, erd);
        capture(0, 4, wt, otx, obs, ord);
        er2 = '0;
        er2[0] = 1'b1;
        er2[41] = 1'b1;
        checks++;
        if (ord !== er2) begin
            failures++;
            $display("FAIL b2b_read: got %h expected %h", ord, er2);
        end
        checks++;
        if (otx !== etx) begin
            failures++;
            $display("FAIL b2b_tx: got %h expected %h", otx, etx);
        end
        checks++;
        if (obs !== ebs) begin
            failures++;
            $display("FAIL b2b_busy: got %h expected %h", obs, ebs);
        end
        checks++;
        if (fe[0] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_empty: got %b expected 1", fe[0]);
        end
    endtask

    task automatic test_parity();
        int wt;
        logic pexp;
        logic [127:0] otx, obs, ord, etx, ebs, erd;
        for (int d = 1; d < 3; d++) begin
            push(d, 8'h07);
            model(cdiv[d], cpar[d], cstop[d], 32'h07, 1, etx, ebs, erd);
            capture(d, 4, wt, otx, obs, ord);
            pexp = (d == 1) ? 1'b1 : 1'b0;
            checks++;
            if (otx[18] !== pexp) begin
                failures++;
                $display("FAIL parity_bit mode %0d: got %b expected %b",
                         cpar[d], otx[18], pexp);
            end
            checks++;
            if (otx !== etx) begin
                failures++;
                $display("FAIL parity_tx mode %0d: got %h expected %h",
                         cpar[d], otx, etx);
            end
            checks++;
            if ($countones(obs) !== 24) begin
                failures++;
                $display("FAIL parity_len mode %0d: got %0d expected 24",
                         cpar[d], $countones(obs));
            end
        end
    endtask

    task automatic test_reset_mid();
        int wt;
        logic [127:0] otx, obs, ord, etx, ebs, erd;
        push(0, 8'hFF);
        push(0, 8'h12);
        wt = 0;
        while (wt < 4 && rd[0] !== 1'b1) begin
            @(negedge clk);
            wt++;
        end
        checks++;
        if (rd[0] !== 1'b1) begin
            failures++;
            $display("FAIL mid_start: read=%b expected 1", rd[0]);
        end
        repeat (17) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (txs[0] !== 1'b1 || bs[0] !== 1'b0 || rd[0] !== 1'b0) begin
            failures++;
            $display("FAIL mid_async: tx=%b busy=%b read=%b expected 1 0 0",
                     txs[0], bs[0], rd[0]);
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (rd[0] !== 1'b0 || txs[0] !== 1'b1 || wp[0] - rp[0] !== 1) begin
                failures++;
                $display("FAIL mid_hold: read=%b tx=%b queued=%0d expected 0 1 1",
                         rd[0], txs[0], wp[0] - rp[0]);
            end
        end
        rst_n = 1'b1;
        model(cdiv[0], cpar[0], cstop[0], 32'h12, 1, etx, ebs, erd);
        capture(0, 4, wt, otx, obs, ord);
        checks++;
        if (wt !== 1 || otx !== etx) begin
            failures++;
            $display("FAIL mid_next: waited %0d tx %h expected 1 %h",
                     wt, otx, etx);
        end
    endtask

    task automatic test_random();
        int wt, nw;
        logic [31:0] words;
        logic [127:0] otx, obs, ord, etx, ebs, erd;
        for (int r = 0; r < 4; r++) begin
            for (int d = 0; d < 3; d++) begin
                nw = $urandom_range((d == 0) ? 3 : 4, 1);
                words = $urandom;
                for (int i = 0; i < nw; i++) push(d, words[i*8 +: 8]);
                model(cdiv[d], cpar[d], cstop[d], words, nw, etx, ebs, erd);
                capture(d, 4, wt, otx, obs, ord);
                checks++;
                if (otx !== etx) begin
                    failures++;
                    $display("FAIL rand_tx d%0d: got %h expected %h",
                             d, otx, etx);
                end
                checks++;
                if (obs !== ebs || ord !== erd) begin
                    failures++;
                    $display("FAIL rand_ctl d%0d: busy %h read %h expected %h %h",
                             d, obs, ord, ebs, erd);
                end
                checks++;
                if (fe[d] !== 1'b1) begin
                    failures++;
                    $display("FAIL rand_empty d%0d: got %b expected 1", d, fe[d]);
                end
            end
        end
    endtask

    task automatic test_empty();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (rd[d] !== 1'b0 || txs[d] !== 1'b1 || bs[d] !== 1'b0) begin
                    failures++;
                    $display("FAIL empty d%0d: read=%b tx=%b busy=%b expected 0 1 0",
                             d, rd[d], txs[d], bs[d]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_reset_mid();
        test_random();
        test_empty();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
